bip_sequencer: RTL and testbench
================================

# bip_sequencer

Multi-cycle fetch/decode/execute controller for the BIP core. Fetches 16-bit instructions from program memory over a req/ack handshake, decodes the 5-bit opcode, and drives the accumulator/ALU/data-RAM control strobes in per-phase order. Also owns the program counter, a retired-instruction counter and halt/illegal-opcode status. Sits between program memory and the existing datapath, replacing the single-cycle combinational control path.

## Interface
- PC_WIDTH, 11: program counter and operand width; instruction is {opcode[4:0], operand[PC_WIDTH-1:0]}.
- CNT_WIDTH, 16: width of retired-instruction counter.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all reset values immediately.
- start  in  1  one-cycle pulse; honoured only in IDLE or HALTED.
- imem_ack  in  1  program memory has `imem_data` valid this cycle.
- imem_data  in  5+PC_WIDTH  instruction word.
- imem_req  out  1  fetch request, held until acked.
- pc  out  PC_WIDTH  current program counter, also the fetch address.
- operand  out  PC_WIDTH  IR[PC_WIDTH-1:0], to datapath immediate/RAM address.
- SelA  out  2  accumulator input select (00 RAM, 01 immediate, 10 ALU).
- SelB  out  1  ALU B select (0 RAM, 1 immediate).
- Op  out  1  ALU op (1 add, 0 sub).
- WrAcc  out  1  accumulator write strobe.
- WrRam  out  1  data RAM write strobe.
- RdRam  out  1  data RAM read enable.
- busy  out  1  high in FETCH/DEC/EXEC_RD/EXEC_WB.
- halted  out  1  high in HALTED.
- illegal  out  1  sticky; set when an opcode > 5'b00111 is decoded.
- instr_count  out  CNT_WIDTH  instructions retired since last start.

## Operation
- States: IDLE, FETCH, DEC, EXEC_RD, EXEC_WB, HALTED. Registers: state, pc, IR, instr_count, illegal.
- IDLE: all strobes 0. start -> pc=0, instr_count=0, illegal=0, go FETCH.
- FETCH: imem_req=1. On imem_ack: IR<=imem_data, go DEC. No ack: stay.
- DEC: strobes 0. Opcode 00000 (HALT) -> HALTED. 00010 LD, 00100 ADD, 00110 SUB -> EXEC_RD. 00001 STO, 00011 LDI, 00101 ADDI, 00111 SUBI -> EXEC_WB. Any other -> illegal<=1, HALTED.
- EXEC_RD: RdRam=1, SelA/SelB/Op per opcode, WrAcc=0. Always -> EXEC_WB.
- EXEC_WB: one cycle, strobes per opcode:
  - STO: WrRam=1.
  - LD: RdRam=1, SelA=00, WrAcc=1.
  - LDI: SelA=01, WrAcc=1.
  - ADD: RdRam=1, SelA=10, SelB=0, Op=1, WrAcc=1.
  - ADDI: SelA=10, SelB=1, Op=1, WrAcc=1.
  - SUB: RdRam=1, SelA=10, SelB=0, Op=0, WrAcc=1.
  - SUBI: SelA=10, SelB=1, Op=0, WrAcc=1.
  - Then pc<=pc+1 (mod 2^PC_WIDTH, all-ones wraps to 0), instr_count<=instr_count+1 saturating at all-ones, go FETCH.
- HALTED: strobes 0, pc and IR hold. start -> same as IDLE start (pc=0, counters/illegal cleared), go FETCH.
- Strobes are Moore outputs decoded from state and IR; every strobe not listed for a state is 0. operand always reflects IR.

## Timing
- Reset values: state IDLE, pc 0, IR 0, operand 0, instr_count 0, all strobes/imem_req/busy/halted/illegal 0.
- Immediate ops and STO: 3 cycles/instruction with ack in first FETCH cycle (FETCH, DEC, EXEC_WB). LD/ADD/SUB: 4 cycles. Each wait cycle on imem_ack adds 1.
- HALT reaches HALTED 2 cycles after acked fetch; HALT does not increment pc or instr_count.
- start outside IDLE/HALTED ignored. imem_ack outside FETCH ignored. start and ack coinciding in HALTED: start wins, FETCH entered next cycle, ack not consumed.
- imem_data sampled only on the cycle imem_ack=1 in FETCH.
- WrRam and WrAcc each high for exactly one cycle per instruction; never both high.
- Reset asserted mid-instruction: strobes drop asynchronously, no partial pc/count update survives.

## Test plan
- Reset then start, ack immediately, program LDI 5; ADDI 3; STO 7; HALT -> WrAcc pulses at cycles 3 and 6 after start, WrRam once with operand=7, halted=1, pc=3, instr_count=3.
- LD 2 with imem_ack delayed 4 cycles -> imem_req held 5 cycles, then RdRam high 2 cycles, WrAcc only in second, SelA=00.
- SUB 9 and ADD 9 back to back -> EXEC_WB shows SelA=10, SelB=0, Op=0 then Op=1, RdRam=1 in both.
- Opcode 5'b01010 fetched -> illegal=1, halted=1, no strobes, pc unchanged; start clears illegal and refetches from pc=0.
- pc preset to all-ones via LDI run of 2^PC_WIDTH-1 instructions (PC_WIDTH=3 for sim) -> next retire wraps pc to 0; instr_count saturation checked with CNT_WIDTH=2 -> holds 3.
- Assert reset during EXEC_WB of STO -> WrRam falls same cycle, state IDLE, pc=0, start ignored while reset held.

Source files
------------

// File: rtl/bip_sequencer.sv
// bip_sequencer: multi-cycle fetch/decode/execute controller for the BIP core.
// It fetches instructions over a req/ack handshake and decodes the 5-bit opcode.
// It drives the accumulator, ALU and data-RAM strobes phase by phase.
// It also owns the program counter, the retired-instruction counter and the
// halt/illegal status.
module bip_sequencer #(
  parameter int PC_WIDTH  = 11,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  imem_ack,
  input  logic [PC_WIDTH+4:0]   imem_data,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   operand,
  output logic [1:0]            SelA,
  output logic                  SelB,
  output logic                  Op,
  output logic                  WrAcc,
  output logic                  WrRam,
  output logic                  RdRam,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DEC, EXEC_RD, EXEC_WB, HALTED
  } seqStateT;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  seqStateT              state, nextState;
  logic [PC_WIDTH+4:0]   ir, nextIr;
  logic [PC_WIDTH-1:0]   nextPc;
  logic [CNT_WIDTH-1:0]  nextCount;
  logic                  nextIllegal;
  logic [4:0]            curOpcode, nextOpcode;

  logic [1:0] nSelA;
  logic       nSelB, nOp, nWrAcc, nWrRam, nRdRam, nReq, nBusy, nHalted;

  assign operand    = ir[PC_WIDTH-1:0];
  assign curOpcode  = ir[PC_WIDTH+4:PC_WIDTH];
  assign nextOpcode = nextIr[PC_WIDTH+4:PC_WIDTH];

  // Next-state and architectural register update for the fetch/decode/execute sequence.
  always_comb begin
    nextState   = state;
    nextIr      = ir;
    nextPc      = pc;
    nextCount   = instr_count;
    nextIllegal = illegal;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          nextState   = FETCH;
          nextPc      = '0;
          nextCount   = '0;
          nextIllegal = 1'b0;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          nextIr    = imem_data;
          nextState = DEC;
        end
      end
      DEC: begin
        case (curOpcode)
          OP_HALT:                     nextState = HALTED;
          OP_LD, OP_ADD, OP_SUB:       nextState = EXEC_RD;
          OP_STO, OP_LDI, OP_ADDI,
          OP_SUBI:                     nextState = EXEC_WB;
          default: begin
            nextIllegal = 1'b1;
            nextState   = HALTED;
          end
        endcase
      end
      EXEC_RD: nextState = EXEC_WB;
      EXEC_WB: begin
        nextPc    = pc + 1'b1;
        nextCount = (instr_count == '1) ? instr_count : instr_count + 1'b1;
        nextState = FETCH;
      end
      default: nextState = IDLE;
    endcase
  end

  // Decode the strobes for the state being entered, so the registered outputs line up with it.
  always_comb begin
    nSelA   = 2'b00;
    nSelB   = 1'b0;
    nOp     = 1'b0;
    nWrAcc  = 1'b0;
    nWrRam  = 1'b0;
    nRdRam  = 1'b0;
    nReq    = 1'b0;
    nBusy   = 1'b0;
    nHalted = 1'b0;
    case (nextState)
      FETCH: begin
        nReq  = 1'b1;
        nBusy = 1'b1;
      end
      DEC: nBusy = 1'b1;
      EXEC_RD: begin
        nBusy  = 1'b1;
        nRdRam = 1'b1;
        case (nextOpcode)
          OP_ADD: begin
            nSelA = 2'b10;
            nOp   = 1'b1;
          end
          OP_SUB:  nSelA = 2'b10;
          default: nSelA = 2'b00;
        endcase
      end
      EXEC_WB: begin
        nBusy = 1'b1;
        case (nextOpcode)
          OP_STO: nWrRam = 1'b1;
          OP_LD: begin
            nRdRam = 1'b1;
            nWrAcc = 1'b1;
          end
          OP_LDI: begin
            nSelA  = 2'b01;
            nWrAcc = 1'b1;
          end
          OP_ADD: begin
            nRdRam = 1'b1;
            nSelA  = 2'b10;
            nOp    = 1'b1;
            nWrAcc = 1'b1;
          end
          OP_ADDI: begin
            nSelA  = 2'b10;
            nSelB  = 1'b1;
            nOp    = 1'b1;
            nWrAcc = 1'b1;
          end
          OP_SUB: begin
            nRdRam = 1'b1;
            nSelA  = 2'b10;
            nWrAcc = 1'b1;
          end
          OP_SUBI: begin
            nSelA  = 2'b10;
            nSelB  = 1'b1;
            nWrAcc = 1'b1;
          end
          default: ;
        endcase
      end
      HALTED: nHalted = 1'b1;
      default: ;
    endcase
  end

  // State, architectural registers and registered strobes; reset clears all of them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      pc          <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      SelA        <= 2'b00;
      SelB        <= 1'b0;
      Op          <= 1'b0;
      WrAcc       <= 1'b0;
      WrRam       <= 1'b0;
      RdRam       <= 1'b0;
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= nextState;
      ir          <= nextIr;
      pc          <= nextPc;
      instr_count <= nextCount;
      illegal     <= nextIllegal;
      SelA        <= nSelA;
      SelB        <= nSelB;
      Op          <= nOp;
      WrAcc       <= nWrAcc;
      WrRam       <= nWrRam;
      RdRam       <= nRdRam;
      imem_req    <= nReq;
      busy        <= nBusy;
      halted      <= nHalted;
    end
  end

endmodule

// File: tb/tb_bip_sequencer.sv
// Testbench for bip_sequencer: directed programs with a strobe scoreboard.
// A second, narrow instance exercises pc wrap and counter saturation.
module tb_bip_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ackGate;
  logic [15:0] prog [0:15];

  logic        imemAck;
  logic [15:0] imemData;
  logic        imemReq;
  logic [10:0] pc, operand;
  logic [1:0]  SelA;
  logic        SelB, Op, WrAcc, WrRam, RdRam, busy, halted, illegal;
  logic [15:0] instrCount;

  logic        sStart;
  logic        sAck;
  logic [7:0]  sData;
  logic        sReq;
  logic [2:0]  sPc, sOperand;
  logic [1:0]  sSelA;
  logic        sSelB, sOp, sWrAcc, sWrRam, sRdRam, sBusy, sHalted, sIllegal;
  logic [1:0]  sCount;

  typedef struct {
    logic [1:0]  selA;
    logic        selB, op, wrAcc, wrRam, rdRam;
    logic [10:0] operand;
    int          cycle;
  } expT;

  expT sbq[$];
  expT monE;
  int  tests = 0;
  int  fails = 0;
  int  cycleCnt = 0;

  assign imemAck  = imemReq & ackGate;
  assign imemData = prog[pc[3:0]];
  assign sAck     = sReq;
  assign sData    = {5'b00011, 3'b000};

  bip_sequencer #(.PC_WIDTH(11), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_ack(imemAck), .imem_data(imemData),
    .imem_req(imemReq), .pc(pc), .operand(operand), .SelA(SelA), .SelB(SelB), .Op(Op),
    .WrAcc(WrAcc), .WrRam(WrRam), .RdRam(RdRam), .busy(busy), .halted(halted),
    .illegal(illegal), .instr_count(instrCount)
  );

  bip_sequencer #(.PC_WIDTH(3), .CNT_WIDTH(2)) smallDut (
    .clk(clk), .reset(reset), .start(sStart), .imem_ack(sAck), .imem_data(sData),
    .imem_req(sReq), .pc(sPc), .operand(sOperand), .SelA(sSelA), .SelB(sSelB), .Op(sOp),
    .WrAcc(sWrAcc), .WrRam(sWrRam), .RdRam(sRdRam), .busy(sBusy), .halted(sHalted),
    .illegal(sIllegal), .instr_count(sCount)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle stamp used to check strobe timing relative to start.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [15:0] mk(input logic [4:0] opc, input logic [10:0] opr);
    return {opc, opr};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [1:0] sa, input logic sb, input logic op, input logic wa,
                         input logic wr, input logic rd, input logic [10:0] opr, input int cyc);
    expT e;
    e.selA = sa; e.selB = sb; e.op = op; e.wrAcc = wa; e.wrRam = wr; e.rdRam = rd;
    e.operand = opr; e.cycle = cyc;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(output int c);
    @(negedge clk);
    c = cycleCnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitHalted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      tests++;
      fails++;
      $display("[TB] FAIL haltTimeout: got halted=0 expected halted=1 within %0d cycles", budget);
    end
  endtask

  // Monitor: every cycle with an active datapath strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && (RdRam || WrAcc || WrRam)) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedStrobe: got Rd=%0b WrAcc=%0b WrRam=%0b expected none", RdRam, WrAcc, WrRam);
      end else begin
        monE = sbq.pop_front();
        checkOutput("strobeSelA", SelA, monE.selA);
        checkOutput("strobeSelB", SelB, monE.selB);
        checkOutput("strobeOp", Op, monE.op);
        checkOutput("strobeWrAcc", WrAcc, monE.wrAcc);
        checkOutput("strobeWrRam", WrRam, monE.wrRam);
        checkOutput("strobeRdRam", RdRam, monE.rdRam);
        checkOutput("strobeOperand", operand, monE.operand);
        checkOutput("strobeCycle", cycleCnt, monE.cycle);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed programs.
  initial begin
    int c;
    int reqCycles;
    reset = 1'b1; start = 1'b0; sStart = 1'b0; ackGate = 1'b1;
    for (int i = 0; i < 16; i++) prog[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetPc", pc, 0);
    checkOutput("resetOperand", operand, 0);
    checkOutput("resetCount", instrCount, 0);
    checkOutput("resetStrobes", {imemReq, SelA, SelB, Op, WrAcc, WrRam, RdRam}, 0);
    checkOutput("resetStatus", {busy, halted, illegal}, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleBusy", busy, 0);

    // LDI 5; ADDI 3; STO 7; HALT
    prog[0] = mk(5'b00011, 11'd5);
    prog[1] = mk(5'b00101, 11'd3);
    prog[2] = mk(5'b00001, 11'd7);
    prog[3] = mk(5'b00000, 11'd0);
    applyStimulus(c);
    pushExp(2'b01, 0, 0, 1, 0, 0, 11'd5, c + 3);
    pushExp(2'b10, 1, 1, 1, 0, 0, 11'd3, c + 6);
    pushExp(2'b00, 0, 0, 0, 1, 0, 11'd7, c + 9);
    waitHalted(40);
    checkOutput("prog1HaltCycle", cycleCnt, c + 12);
    checkOutput("prog1Pc", pc, 3);
    checkOutput("prog1Count", instrCount, 3);
    checkOutput("prog1Illegal", illegal, 0);
    checkOutput("prog1Busy", busy, 0);

    // LD 2 with the ack delayed four cycles
    prog[0] = mk(5'b00010, 11'd2);
    prog[1] = mk(5'b00000, 11'd0);
    ackGate = 1'b0;
    applyStimulus(c);
    reqCycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (imemReq) reqCycles++;
      @(negedge clk);
    end
    ackGate = 1'b1;
    pushExp(2'b00, 0, 0, 0, 0, 1, 11'd2, c + 7);
    pushExp(2'b00, 0, 0, 1, 0, 1, 11'd2, c + 8);
    if (imemReq) reqCycles++;
    @(negedge clk);
    checkOutput("ldReqCycles", reqCycles, 5);
    checkOutput("ldReqDropped", imemReq, 0);
    waitHalted(40);
    checkOutput("ldPc", pc, 1);
    checkOutput("ldCount", instrCount, 1);

    // SUB 9; ADD 9; HALT
    prog[0] = mk(5'b00110, 11'd9);
    prog[1] = mk(5'b00100, 11'd9);
    prog[2] = mk(5'b00000, 11'd0);
    applyStimulus(c);
    pushExp(2'b10, 0, 0, 0, 0, 1, 11'd9, c + 3);
    pushExp(2'b10, 0, 0, 1, 0, 1, 11'd9, c + 4);
    pushExp(2'b10, 0, 1, 0, 0, 1, 11'd9, c + 7);
    pushExp(2'b10, 0, 1, 1, 0, 1, 11'd9, c + 8);
    waitHalted(40);
    checkOutput("subAddPc", pc, 2);
    checkOutput("subAddCount", instrCount, 2);

    // LDI 2 then an illegal opcode
    prog[0] = mk(5'b00011, 11'd2);
    prog[1] = mk(5'b01010, 11'd4);
    applyStimulus(c);
    pushExp(2'b01, 0, 0, 1, 0, 0, 11'd2, c + 3);
    waitHalted(40);
    checkOutput("illegalHaltCycle", cycleCnt, c + 6);
    checkOutput("illegalFlag", illegal, 1);
    checkOutput("illegalPc", pc, 1);
    checkOutput("illegalCount", instrCount, 1);
    prog[0] = mk(5'b00011, 11'd6);
    prog[1] = mk(5'b00000, 11'd0);
    applyStimulus(c);
    checkOutput("restartIllegalCleared", illegal, 0);
    checkOutput("restartPc", pc, 0);
    checkOutput("restartCount", instrCount, 0);
    checkOutput("restartBusy", {busy, halted, imemReq}, 3'b101);
    pushExp(2'b01, 0, 0, 1, 0, 0, 11'd6, c + 3);
    waitHalted(40);
    checkOutput("restartFinalPc", pc, 1);
    checkOutput("restartFinalCount", instrCount, 1);

    // Reset during the write-back of STO
    prog[0] = mk(5'b00011, 11'd1);
    prog[1] = mk(5'b00001, 11'd7);
    prog[2] = mk(5'b00000, 11'd0);
    applyStimulus(c);
    pushExp(2'b01, 0, 0, 1, 0, 0, 11'd1, c + 3);
    pushExp(2'b00, 0, 0, 0, 1, 0, 11'd7, c + 6);
    repeat (5) @(negedge clk);
    checkOutput("stoWrRamBeforeReset", WrRam, 1);
    checkOutput("stoPcBeforeReset", pc, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("resetWrRamDrop", WrRam, 0);
    checkOutput("resetMidPc", pc, 0);
    checkOutput("resetMidCount", instrCount, 0);
    checkOutput("resetMidStatus", {busy, halted}, 0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("startDuringReset", {busy, imemReq}, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterReset", {busy, halted, imemReq}, 0);

    // Narrow instance: pc wrap at PC_WIDTH=3, count saturation at CNT_WIDTH=2
    @(negedge clk);
    c = cycleCnt;
    sStart = 1'b1;
    @(negedge clk);
    sStart = 1'b0;
    repeat (21) @(negedge clk);
    checkOutput("smallPcAllOnes", sPc, 7);
    checkOutput("smallCountSat", sCount, 3);
    repeat (3) @(negedge clk);
    checkOutput("smallPcWrap", sPc, 0);
    checkOutput("smallCountHold", sCount, 3);

    checkOutput("scoreboardEmpty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
